nrzi_rx_decoder: RTL and testbench

//   USB receive-side NRZI decoder with bit unstuffing and word assembly; parametrised successor of the single-bit decoder.

---
 rtl/nrzi_rx_decoder.sv | 137 +++++++++++++
 tb/tb_nrzi_rx_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nrzi_rx_decoder.sv
// USB receive NRZI decoder: bit unstuffing, stuffing-violation detection
// and LSB-first word assembly between strobe timing and the packet FSM.
module nrzi_rx_decoder #(
    parameter int WORD_W     = 8,
    parameter int STUFF_RUN  = 6,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_plus,
    input  logic              shift_enable,
    input  logic              eop,
    input  logic              start,
    output logic              d_orig,
    output logic              bit_valid,
    output logic              stuff_drop,
    output logic              stuff_err,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              align_err,
    output logic              busy
);

    localparam int OW = $clog2(STUFF_RUN + 1);
    localparam int BW = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state, n_state;
    logic              prev_level, n_prev;
    logic              n_dorig;
    logic [OW-1:0]     ones_cnt, n_ones;
    logic [BW-1:0]     bit_cnt, n_bitcnt, base_cnt;
    logic [WORD_W-1:0] shreg, n_shreg, base_sh, n_word;
    logic              n_bv, n_drop, n_err, n_wv, n_align;
    logic              dec, starting, assemble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prev_level <= IDLE_LEVEL;
            d_orig     <= 1'b1;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            word_out   <= '0;
            bit_valid  <= 1'b0;
            stuff_drop <= 1'b0;
            stuff_err  <= 1'b0;
            word_valid <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            state      <= n_state;
            prev_level <= n_prev;
            d_orig     <= n_dorig;
            ones_cnt   <= n_ones;
            bit_cnt    <= n_bitcnt;
            shreg      <= n_shreg;
            word_out   <= n_word;
            bit_valid  <= n_bv;
            stuff_drop <= n_drop;
            stuff_err  <= n_err;
            word_valid <= n_wv;
            align_err  <= n_align;
        end
    end

    always_comb begin
        n_state  = state;
        n_prev   = prev_level;
        n_dorig  = d_orig;
        n_ones   = ones_cnt;
        n_bitcnt = bit_cnt;
        n_shreg  = shreg;
        n_word   = word_out;
        n_bv     = 1'b0;
        n_drop   = 1'b0;
        n_err    = 1'b0;
        n_wv     = 1'b0;
        n_align  = 1'b0;
        dec      = (d_plus == prev_level);
        starting = (state == IDLE) && start;
        assemble = (state == RECV) || starting;
        base_cnt = starting ? '0 : bit_cnt;
        base_sh  = starting ? '0 : shreg;

        if (eop) begin
            n_state  = IDLE;
            n_prev   = IDLE_LEVEL;
            n_dorig  = 1'b1;
            n_ones   = '0;
            n_bitcnt = '0;
            n_align  = (state == RECV) && (bit_cnt != '0);
        end else begin
            if (starting) begin
                n_state  = RECV;
                n_bitcnt = '0;
                n_shreg  = '0;
            end
            if (shift_enable) begin
                n_prev = d_plus;
                if (ones_cnt == OW'(STUFF_RUN)) begin
                    n_ones = '0;
                    if (dec) begin
                        n_err = 1'b1;
                        if (assemble)
                            n_state = ERR;
                    end else begin
                        n_drop = 1'b1;
                    end
                end else begin
                    n_dorig = dec;
                    n_bv    = 1'b1;
                    n_ones  = dec ? ones_cnt + OW'(1) : '0;
                    if (assemble) begin
                        // LSB-first: newest bit enters at the MSB
                        n_shreg = {dec, base_sh[WORD_W-1:1]};
                        if (base_cnt == BW'(WORD_W - 1)) begin
                            n_word   = n_shreg;
                            n_wv     = 1'b1;
                            n_bitcnt = '0;
                        end else begin
                            n_bitcnt = base_cnt + BW'(1);
                        end
                    end
                end
            end
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed bench for nrzi_rx_decoder: words, unstuffing, stuff errors,
// partial words, collisions and asynchronous reset.
module tb_nrzi_rx_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_plus;
    logic       shift_enable;
    logic       eop;
    logic       start;
    logic       d_orig;
    logic       bit_valid;
    logic       stuff_drop;
    logic       stuff_err;
    logic [7:0] word_out;
    logic       word_valid;
    logic       align_err;
    logic       busy;

    int n_vec  = 0;
    int n_err  = 0;
    int bv_cnt = 0;
    int wv_cnt = 0;
    int bv0, wv0;

    nrzi_rx_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .d_plus       (d_plus),
        .shift_enable (shift_enable),
        .eop          (eop),
        .start        (start),
        .d_orig       (d_orig),
        .bit_valid    (bit_valid),
        .stuff_drop   (stuff_drop),
        .stuff_err    (stuff_err),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .align_err    (align_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters: each pulse is seen at the edge after it was set
    always @(posedge clk) begin
        if (!rst && bit_valid)  bv_cnt = bv_cnt + 1;
        if (!rst && word_valid) wv_cnt = wv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic se, input logic d,
                        input logic e, input logic s);
        @(negedge clk);
        shift_enable = se;
        d_plus       = d;
        eop          = e;
        start        = s;
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
        eop          = 1'b0;
        start        = 1'b0;
    endtask

    function automatic logic [4:0] pulses();
        return {bit_valid, stuff_drop, stuff_err, word_valid, align_err};
    endfunction

    // Line levels encoding 0xA5 from idle J, and the decoded bits
    logic [7:0] a5_line = 8'b1100_1001;
    logic [7:0] a5_dec  = 8'b1010_0101;

    initial begin
        rst = 1'b1; d_plus = 1'b1; shift_enable = 1'b0;
        eop = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, i[0], 1'b0, 1'b0);
        chk("rst_dorig", d_orig, 1);
        chk("rst_busy", busy, 0);
        chk("rst_word", word_out, 0);
        chk("rst_pulses", pulses(), 0);
        @(negedge clk); rst = 1'b0; d_plus = 1'b1;

        // Word 0xA5 with start on its own cycle
        bv0 = bv_cnt; wv0 = wv_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("a5_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, a5_line[i], 1'b0, 1'b0);
            chk("a5_bv", bit_valid, 1);
            chk("a5_dorig", d_orig, a5_dec[i]);
            chk("a5_wv", word_valid, (i == 7) ? 1 : 0);
        end
        chk("a5_word", word_out, 8'hA5);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("a5_align", align_err, 0);
        chk("a5_idle", busy, 0);
        chk("a5_bvcnt", bv_cnt - bv0, 8);
        chk("a5_wvcnt", wv_cnt - wv0, 1);

        // Asynchronous reset mid-packet
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #2; rst = 1'b1; #1;
        chk("arst_word", word_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dorig", d_orig, 1);
        chk("arst_pulses", pulses(), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i[0], 1'b0, 1'b0);
            chk("arst_hold", {pulses(), busy, d_orig}, 7'b0000001);
        end
        @(negedge clk); rst = 1'b0; d_plus = 1'b1;

        // Six ones, stuffed zero, then two more ones
        wv0 = wv_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            chk("sd_bv", bit_valid, 1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sd_drop", stuff_drop, 1);
        chk("sd_nobv", bit_valid, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sd_wv7", word_valid, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sd_wv8", word_valid, 1);
        chk("sd_word", word_out, 8'hFF);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sd_wvcnt", wv_cnt - wv0, 1);

        // Seven ones: stuffing violation
        wv0 = wv_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("se_err", stuff_err, 1);
        chk("se_busy", busy, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("se_start_ign", busy, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("se_wvcnt", wv_cnt - wv0, 0);

        // Recovery, start coinciding with the first strobe
        step(1'b1, a5_line[0], 1'b0, 1'b1);
        chk("rc_busy", busy, 1);
        chk("rc_bv0", bit_valid, 1);
        for (int i = 1; i < 8; i++) step(1'b1, a5_line[i], 1'b0, 1'b0);
        chk("rc_wv", word_valid, 1);
        chk("rc_word", word_out, 8'hA5);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // Partial word
        wv0 = wv_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pw_dorig0", d_orig, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pw_align", align_err, 1);
        chk("pw_dorig", d_orig, 1);
        chk("pw_busy", busy, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pw_align_pulse", align_err, 0);
        chk("pw_wvcnt", wv_cnt - wv0, 0);

        // Collisions
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("col_es_busy", busy, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("col_pre_dorig", d_orig, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("col_ee_bv", bit_valid, 0);
        chk("col_ee_dorig", d_orig, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("col_next_bv", bit_valid, 1);
        chk("col_next_dorig", d_orig, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
